// File: rtl/ex_pkg.sv
// ex_pkg -- shared definitions for the execute stage.
//   * default datapath / register-index widths
//   * 4-bit ALU op encodings (9-15 fall back to ADD)
//   * execute-stage FSM state constants
package ex_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REGW_DEFAULT = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/seq_mul.sv
// seq_mul -- iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           latch operands a/b and begin (ignored while busy)
//   a, b            multiplicand / multiplier
//   busy            iterations in progress or final result pending
//   done            product holds the finished result this cycle
//   product         low XLEN bits of a*b (unsigned)
// After start, XLEN iterations run on the following XLEN edges; done is
// then high for one cycle and busy clears on the next edge.
module seq_mul
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic            busy_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] acc_r;
    logic [XLEN-1:0] mcand_r;
    logic [XLEN-1:0] mplier_r;
    logic            last_s;

    // All iterations finished: the accumulator holds the product
    always_comb begin
        last_s = busy_r & (cnt_r == CNT_LAST);
    end

    // Operand latch, iteration counter and shift-add datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r   <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {XLEN{1'b0}};
            mcand_r  <= {XLEN{1'b0}};
            mplier_r <= {XLEN{1'b0}};
        end else if (start && !busy_r) begin
            busy_r   <= 1'b1;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {XLEN{1'b0}};
            mcand_r  <= a;
            mplier_r <= b;
        end else if (busy_r) begin
            if (last_s) begin
                busy_r <= 1'b0;
                cnt_r  <= {CW{1'b0}};
            end else begin
                // Bits shifted out of mcand only affect product bits >= XLEN
                if (mplier_r[0]) begin
                    acc_r <= acc_r + mcand_r;
                end
                mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
                cnt_r    <= cnt_r + CNT_ONE;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = last_s;
    assign product = acc_r;

endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc -- multi-cycle execute stage with operand forwarding.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid / in_ready           issue handshake
//   rs_data, rt_data, imm         operands and sign-extended immediate
//   rs, rt, rd                    source / destination register indices
//   alu_src, reg_dst, op          in2 select, dest select, ALU op
//   wb_en, mem_rd, mem_wr         control passed through to the result
//   wb_fwd_en/_reg/_data          writeback-stage forwarding source
//   out_valid / out_ready         result handshake
//   out_result, out_store_data    ALU/MUL result, forwarded rt value
//   out_dest, out_wb_en,
//   out_mem_rd, out_mem_wr        passed-through control
//   out_zero                      out_result == 0
// Single-cycle ops load the output register on the accept edge; MUL
// parks the stage in BUSY while seq_mul iterates.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned REGW = REGW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic [XLEN-1:0] imm,
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rt,
    input  logic [REGW-1:0] rd,
    input  logic            alu_src,
    input  logic            reg_dst,
    input  logic [3:0]      op,
    input  logic            wb_en,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic            wb_fwd_en,
    input  logic [REGW-1:0] wb_fwd_reg,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [REGW-1:0] out_dest,
    output logic            out_wb_en,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [0:0]      state_r;
    logic [0:0]      state_nxt_s;
    logic [XLEN-1:0] in1_s;
    logic [XLEN-1:0] rt_fwd_s;
    logic [XLEN-1:0] in2_s;
    logic [SHW-1:0]  shamt_s;
    logic [XLEN-1:0] alu_res_s;
    logic [REGW-1:0] dest_s;
    logic            accept_s;
    logic            is_mul_s;
    logic            mul_start_s;
    logic            alu_load_s;
    logic            mul_fin_s;
    logic            mul_busy_s;
    logic            mul_done_s;
    logic [XLEN-1:0] mul_product_s;
    logic [REGW-1:0] mul_dest_r;
    logic            mul_wb_en_r;
    logic            mul_mem_rd_r;
    logic            mul_mem_wr_r;
    logic [XLEN-1:0] mul_store_r;

    // Forwarding mux: output register first, then writeback port, else issued
    // data. A load sitting in the output register has no data yet, so it is
    // excluded; register 0 is hard-wired and never forwarded.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REGW-1:0] idx,
        input logic [XLEN-1:0] issued,
        input logic            ov,
        input logic            owb,
        input logic            ord,
        input logic [REGW-1:0] odest,
        input logic [XLEN-1:0] ores,
        input logic            wen,
        input logic [REGW-1:0] wreg,
        input logic [XLEN-1:0] wdata
    );
        logic [XLEN-1:0] sel;
        if (ov && owb && !ord && (odest != {REGW{1'b0}}) && (odest == idx)) begin
            sel = ores;
        end else if (wen && (wreg != {REGW{1'b0}}) && (wreg == idx)) begin
            sel = wdata;
        end else begin
            sel = issued;
        end
        return sel;
    endfunction

    // Issue handshake and op classification
    always_comb begin
        in_ready    = (state_r == ST_IDLE) & (~out_valid | out_ready);
        accept_s    = in_valid & in_ready;
        is_mul_s    = (op == OP_MUL);
        mul_start_s = accept_s & is_mul_s;
        alu_load_s  = accept_s & ~is_mul_s;
        mul_fin_s   = (state_r == ST_BUSY) & mul_busy_s & mul_done_s;
        dest_s      = reg_dst ? rd : rt;
    end

    // Forwarded operands; in2 forwarding precedes the immediate select
    always_comb begin
        in1_s    = fwd_sel(rs, rs_data, out_valid, out_wb_en, out_mem_rd, out_dest,
                           out_result, wb_fwd_en, wb_fwd_reg, wb_fwd_data);
        rt_fwd_s = fwd_sel(rt, rt_data, out_valid, out_wb_en, out_mem_rd, out_dest,
                           out_result, wb_fwd_en, wb_fwd_reg, wb_fwd_data);
        in2_s    = alu_src ? imm : rt_fwd_s;
        shamt_s  = in2_s[SHW-1:0];
    end

    // Single-cycle ALU; MUL and unused encodings compute ADD (MUL's value is
    // discarded, the multiplier supplies its result)
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (op)
            OP_ADD:  alu_res_s = in1_s + in2_s;
            OP_SUB:  alu_res_s = in1_s - in2_s;
            OP_AND:  alu_res_s = in1_s & in2_s;
            OP_OR:   alu_res_s = in1_s | in2_s;
            OP_XOR:  alu_res_s = in1_s ^ in2_s;
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(in1_s) < $signed(in2_s))};
            OP_SLL:  alu_res_s = in1_s << shamt_s;
            OP_SRL:  alu_res_s = in1_s >> shamt_s;
            default: alu_res_s = in1_s + in2_s;
        endcase
    end

    // FSM next state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mul_start_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_fin_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Control and store data of the in-flight multiply, captured at accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_dest_r   <= {REGW{1'b0}};
            mul_wb_en_r  <= 1'b0;
            mul_mem_rd_r <= 1'b0;
            mul_mem_wr_r <= 1'b0;
            mul_store_r  <= {XLEN{1'b0}};
        end else if (mul_start_s) begin
            mul_dest_r   <= dest_s;
            mul_wb_en_r  <= wb_en;
            mul_mem_rd_r <= mem_rd;
            mul_mem_wr_r <= mem_wr;
            mul_store_r  <= rt_fwd_s;
        end
    end

    seq_mul #(
        .XLEN (XLEN)
    ) u_seq_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (in1_s),
        .b       (in2_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Output register: loads a new result or retires the current one; holds
    // everything while a result waits on out_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_result     <= {XLEN{1'b0}};
            out_store_data <= {XLEN{1'b0}};
            out_dest       <= {REGW{1'b0}};
            out_wb_en      <= 1'b0;
            out_mem_rd     <= 1'b0;
            out_mem_wr     <= 1'b0;
            out_zero       <= 1'b1;
        end else if (alu_load_s) begin
            out_valid      <= 1'b1;
            out_result     <= alu_res_s;
            out_store_data <= rt_fwd_s;
            out_dest       <= dest_s;
            out_wb_en      <= wb_en;
            out_mem_rd     <= mem_rd;
            out_mem_wr     <= mem_wr;
            out_zero       <= (alu_res_s == {XLEN{1'b0}});
        end else if (mul_fin_s) begin
            out_valid      <= 1'b1;
            out_result     <= mul_product_s;
            out_store_data <= mul_store_r;
            out_dest       <= mul_dest_r;
            out_wb_en      <= mul_wb_en_r;
            out_mem_rd     <= mul_mem_rd_r;
            out_mem_wr     <= mul_mem_wr_r;
            out_zero       <= (mul_product_s == {XLEN{1'b0}});
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc -- directed tests for ex_stage_mc (XLEN=32, REGW=5).
module tb_ex_stage_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic        alu_src, reg_dst;
    logic [3:0]  op;
    logic        wb_en, mem_rd, mem_wr;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_reg;
    logic [31:0] wb_fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_dest;
    logic        out_wb_en, out_mem_rd, out_mem_wr, out_zero;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_stage_mc #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .rs(rs), .rt(rt), .rd(rd),
        .alu_src(alu_src), .reg_dst(reg_dst), .op(op),
        .wb_en(wb_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_reg(wb_fwd_reg), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_dest(out_dest), .out_wb_en(out_wb_en),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_zero(out_zero)
    );

    // Present one instruction (rd destination) on the issue port
    task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic asrc, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic wbe,
                         input logic mrd);
        in_valid = 1'b1; op = o; rs_data = a; rt_data = b; imm = im; alu_src = asrc;
        rs = s; rt = t; rd = d; reg_dst = 1'b1; wb_en = wbe; mem_rd = mrd; mem_wr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_run++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL rst_zero: got %b want 1", out_zero); end
        n_run++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL rst_result: got %h want 0", out_result); end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add_fwd();
        drive(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        step();
        n_run++; if (out_result !== 32'd12 || out_valid !== 1'b1) begin n_fail++; $display("FAIL add_first: got %h v=%b want 0000000c v=1", out_result, out_valid); end
        n_run++; if (out_store_data !== 32'd7 || out_dest !== 5'd3) begin n_fail++; $display("FAIL add_meta: got sd=%h d=%0d want sd=7 d=3", out_store_data, out_dest); end
        drive(4'd1, 32'd0, 32'd2, 32'd0, 1'b0, 5'd3, 5'd9, 5'd10, 1'b1, 1'b0);
        step();
        n_run++; if (out_result !== 32'd10) begin n_fail++; $display("FAIL sub_fwd: got %h want 0000000a", out_result); end
    endtask

    task automatic test_priority();
        drive(4'd0, 32'h10, 32'h0, 32'd0, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
        step();
        wb_fwd_en = 1'b1; wb_fwd_reg = 5'd4; wb_fwd_data = 32'h20;
        drive(4'd0, 32'h99, 32'h0, 32'd0, 1'b0, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0);
        step();
        n_run++; if (out_result !== 32'h10) begin n_fail++; $display("FAIL prio_outreg: got %h want 00000010", out_result); end
        drive(4'd0, 32'h99, 32'h0, 32'd0, 1'b0, 5'd4, 5'd0, 5'd11, 1'b1, 1'b0);
        step();
        n_run++; if (out_result !== 32'h20) begin n_fail++; $display("FAIL prio_wbport: got %h want 00000020", out_result); end
        drive(4'd0, 32'h10, 32'h0, 32'd0, 1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        step();
        wb_fwd_reg = 5'd0;
        drive(4'd0, 32'h33, 32'h0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
        step();
        n_run++; if (out_result !== 32'h33) begin n_fail++; $display("FAIL prio_reg0: got %h want 00000033", out_result); end
        wb_fwd_en = 1'b0;
        drive(4'd0, 32'h40, 32'h0, 32'd0, 1'b0, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
        step();
        drive(4'd0, 32'h1, 32'h0, 32'd0, 1'b0, 5'd6, 5'd0, 5'd13, 1'b1, 1'b0);
        step();
        n_run++; if (out_result !== 32'h1) begin n_fail++; $display("FAIL load_nofwd: got %h want 00000001", out_result); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops  [8] = '{4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd12};
        logic [31:0] as   [8] = '{32'h8000_0000, 32'h3, 32'h5, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h8000_0000, 32'h7};
        logic [31:0] bs   [8] = '{32'h1, 32'h0, 32'h5, 32'hFF00, 32'hFF00, 32'hFF00, 32'h0, 32'h8};
        logic [31:0] ims  [8] = '{32'h0, 32'd33, 32'h0, 32'h0, 32'h0, 32'h0, 32'd4, 32'h0};
        logic        srcs [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps [8] = '{32'h1, 32'h6, 32'h0, 32'hF000, 32'hFFF0, 32'h0FF0, 32'h0800_0000, 32'hF};
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], as[i], bs[i], ims[i], srcs[i], 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
            n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            step();
            n_run++; if (out_result !== exps[i] || out_zero !== (exps[i] == 32'h0)) begin
                n_fail++; $display("FAIL b2b_op[%0d]: got %h z=%b want %h", i, out_result, out_zero, exps[i]);
            end
        end
    endtask

    task automatic test_mul();
        int cnt;
        int busy_bad;
        drive(4'd8, 32'hFFFF_FFFF, 32'h3, 32'h0, 1'b0, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        step();
        drive(4'd0, 32'h1, 32'h1, 32'h0, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        cnt = 0;
        busy_bad = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            if (in_ready !== 1'b0) busy_bad++;
            step();
            cnt++;
        end
        n_run++; if (cnt != 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", cnt); end
        n_run++; if (busy_bad != 0) begin n_fail++; $display("FAIL mul_in_ready: got %0d ready cycles want 0", busy_bad); end
        n_run++; if (out_result !== 32'hFFFF_FFFD || out_dest !== 5'd7) begin n_fail++; $display("FAIL mul_result: got %h d=%0d want fffffffd d=7", out_result, out_dest); end
        in_valid = 1'b0;
        step();
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_retire: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        int bad;
        out_ready = 1'b0;
        drive(4'd0, 32'd100, 32'd0, 32'd0, 1'b0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0);
        step();
        drive(4'd0, 32'd200, 32'd0, 32'd0, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd100 || out_dest !== 5'd8) bad++;
            step();
        end
        n_run++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        out_ready = 1'b1;
        #1;
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", in_ready); end
        step();
        n_run++; if (out_result !== 32'd200 || out_dest !== 5'd9) begin n_fail++; $display("FAIL stall_accept: got %h d=%0d want 000000c8 d=9", out_result, out_dest); end
        in_valid = 1'b0;
        step();
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_clear: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int spurious;
        drive(4'd8, 32'd6, 32'd7, 32'd0, 1'b0, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        repeat (10) step();
        #2;
        rst = 1'b0;
        #1;
        n_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_async: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        n_run++; if (out_result !== 32'h0 || out_zero !== 1'b1) begin n_fail++; $display("FAIL mrst_regs: got %h z=%b want 0 z=1", out_result, out_zero); end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready: got %b want 1", in_ready); end
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) spurious++;
            step();
        end
        n_run++; if (spurious != 0) begin n_fail++; $display("FAIL mrst_spurious: got %0d want 0", spurious); end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rs_data = 32'h0; rt_data = 32'h0; imm = 32'h0;
        rs = 5'd0; rt = 5'd0; rd = 5'd0;
        alu_src = 1'b0; reg_dst = 1'b0; op = 4'd0;
        wb_en = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        wb_fwd_en = 1'b0; wb_fwd_reg = 5'd0; wb_fwd_data = 32'h0;
        test_reset();
        test_add_fwd();
        test_priority();
        test_back_to_back();
        test_mul();
        test_stall();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
